// File: rtl/alu_issue_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_pkg
// Shared definitions for the ALU issue stage: ALU opcode values, the issue
// sequencer state encoding and the instruction word field layout with a
// small decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_issue_stage_pkg;

   // ALU opcodes; 3'b110 and 3'b111 are unassigned and passed through as-is.
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_EQ  = 3'b010;
   localparam logic [2:0] OP_GT  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_INV = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   // Instruction word: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] reserved.
   localparam int INSTR_W = 16;
   localparam int FIELD_W = 3;
   localparam int OP_LSB  = 13;
   localparam int RD_LSB  = 10;
   localparam int RS1_LSB = 7;
   localparam int RS2_LSB = 4;

   typedef struct packed {
      logic [FIELD_W-1:0] op;
      logic [FIELD_W-1:0] rd;
      logic [FIELD_W-1:0] rs1;
      logic [FIELD_W-1:0] rs2;
   } instr_t;

   function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
      instr_t d;
      d.op  = w[OP_LSB  +: FIELD_W];
      d.rd  = w[RD_LSB  +: FIELD_W];
      d.rs1 = w[RS1_LSB +: FIELD_W];
      d.rs2 = w[RS2_LSB +: FIELD_W];
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if
// Upstream bundle of the ALU issue stage: instruction handshake plus the host
// register-load port.
//   instr_valid / instr_ready / instr : instruction word handshake
//   ld_valid / ld_addr / ld_data      : host register load (honoured when idle)
// Modports: master = instruction source / host, slave = issue stage.
// ---------------------------------------------------------------------------
interface alu_issue_stage_if #(
   parameter int RA = 3,
   parameter int DW = 32
);
   logic                 instr_valid;
   logic                 instr_ready;
   logic [15:0]          instr;
   logic                 ld_valid;
   logic [RA-1:0]        ld_addr;
   logic signed [DW-1:0] ld_data;

   modport master (
      output instr_valid, instr, ld_valid, ld_addr, ld_data,
      input  instr_ready
   );

   modport slave (
      input  instr_valid, instr, ld_valid, ld_addr, ld_data,
      output instr_ready
   );
endinterface

// File: rtl/alu_issue_stage_regfile.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_regfile
// NREG x DW register file for the ALU issue stage. r0 reads as zero and
// ignores writes. One write port shared by host load and writeback, load
// taking priority (the two are never active together). Cleared by reset.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ld_en/addr/data     host load write request
//   wb_en/addr/data     writeback write request
//   rd1_addr/rd1_data   combinational read port 1
//   rd2_addr/rd2_data   combinational read port 2
//   dbg_addr/dbg_data   combinational debug read port
// ---------------------------------------------------------------------------
module alu_issue_stage_regfile #(
   parameter int NREG = 8,
   parameter int DW   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ld_en,
   input  logic [$clog2(NREG)-1:0]    ld_addr,
   input  logic signed [DW-1:0]       ld_data,
   input  logic                       wb_en,
   input  logic [$clog2(NREG)-1:0]    wb_addr,
   input  logic signed [DW-1:0]       wb_data,
   input  logic [$clog2(NREG)-1:0]    rd1_addr,
   output logic signed [DW-1:0]       rd1_data,
   input  logic [$clog2(NREG)-1:0]    rd2_addr,
   output logic signed [DW-1:0]       rd2_data,
   input  logic [$clog2(NREG)-1:0]    dbg_addr,
   output logic signed [DW-1:0]       dbg_data
);

   logic signed [DW-1:0] mem [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else if (ld_en && ld_addr != '0) begin
         mem[ld_addr] <= ld_data;
      end else if (wb_en && wb_addr != '0) begin
         mem[wb_addr] <= wb_data;
      end
   end

   // Entry 0 is never written; the explicit zero makes r0 independent of it.
   assign rd1_data = (rd1_addr == '0) ? '0 : mem[rd1_addr];
   assign rd2_data = (rd2_addr == '0) ? '0 : mem[rd2_addr];
   assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Sequencer in front of the 32-bit signed ALU. Accepts one instruction per
// handshake, reads both operands from the internal register file, presents
// op/in1/in2 to the ALU, captures its combinational result and writes it
// back. Fixed four-cycle flow IDLE -> READ -> EXEC -> WRITE.
// Optional feature macro: ALU_FLAGS_EN adds flag_z / flag_n outputs.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   up (slave)              instruction handshake + host register load
//   alu_op/alu_in1/alu_in2  registered ALU operands (held outside READ)
//   alu_out                 combinational ALU result
//   done                    one-cycle pulse on writeback
//   result                  last written-back value
//   dbg_addr/dbg_data       combinational register file debug read
//   flag_z/flag_n           (ALU_FLAGS_EN) zero / negative of result
// ---------------------------------------------------------------------------
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int NREG = 8,
   parameter int DW   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   alu_issue_stage_if.slave           up,
   output logic [2:0]                 alu_op,
   output logic signed [DW-1:0]       alu_in1,
   output logic signed [DW-1:0]       alu_in2,
   input  logic signed [DW-1:0]       alu_out,
   output logic                       done,
   output logic signed [DW-1:0]       result,
   input  logic [$clog2(NREG)-1:0]    dbg_addr,
   output logic signed [DW-1:0]       dbg_data
`ifdef ALU_FLAGS_EN
   ,
   output logic                       flag_z,
   output logic                       flag_n
`endif
);

   localparam int RA = $clog2(NREG);

   state_t               state_q, state_d;
   instr_t               instr_q;
   logic signed [DW-1:0] result_q;
   logic signed [DW-1:0] rs1_data, rs2_data;
   logic                 accept, ld_en, wb_en;
   logic                 unused_rsvd;

   assign up.instr_ready = (state_q == ST_IDLE);
   assign accept         = up.instr_valid & up.instr_ready;
   // Host loads only land while idle, so they can never race a writeback.
   assign ld_en          = up.ld_valid & (state_q == ST_IDLE);
   assign wb_en          = (state_q == ST_WRITE);
   assign unused_rsvd    = ^up.instr[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = ST_READ;
         ST_READ:  state_d = ST_EXEC;
         ST_EXEC:  state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   alu_issue_stage_regfile #(.NREG(NREG), .DW(DW)) u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_en    (ld_en),
      .ld_addr  (up.ld_addr),
      .ld_data  (up.ld_data),
      .wb_en    (wb_en),
      .wb_addr  (RA'(instr_q.rd)),
      .wb_data  (result_q),
      .rd1_addr (RA'(instr_q.rs1)),
      .rd1_data (rs1_data),
      .rd2_addr (RA'(instr_q.rs2)),
      .rd2_data (rs2_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   // Stage boundary: IDLE latches the word, READ registers operands, EXEC captures the ALU result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q  <= '0;
         alu_op   <= '0;
         alu_in1  <= '0;
         alu_in2  <= '0;
         result_q <= '0;
      end else begin
         if (accept) instr_q <= decode_instr(up.instr);
         if (state_q == ST_READ) begin
            alu_op  <= instr_q.op;
            alu_in1 <= rs1_data;
            alu_in2 <= rs2_data;
         end
         if (state_q == ST_EXEC) result_q <= alu_out;
      end
   end

   // Stage boundary: WRITE publishes the result; the rf write happens in u_rf on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= wb_en;
         if (wb_en) result <= result_q;
      end
   end

`ifdef ALU_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (wb_en) begin
         flag_z <= (result_q == '0);
         flag_n <= result_q[DW-1];
      end
   end
`endif

endmodule
